// File: rtl/sprite_snapshot_dma.sv
// Snapshot DMA: on each frame_start, reads all actor motion registers and the map scroll
// into a staging bank over the shared register-file port, writes frame-lock, then commits to the shadow bank.
module sprite_snapshot_dma #(
  parameter logic [5:0]  FRAME_LOCK_ADDR  = 6'd32,
  parameter logic [15:0] FRAME_LOCK_VALUE = 16'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        bus_gnt,
  output logic        bus_req,
  output logic [5:0]  reg_addr,
  output logic [15:0] wdata,
  output logic        we,
  input  logic [15:0] rdata,
  output logic [39:0] actor_x,
  output logic [39:0] actor_y,
  output logic [9:0]  actor_rot,
  output logic [39:0] actor_timer,
  output logic [7:0]  map_x,
  output logic [7:0]  map_y,
  output logic        snap_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    LOCK,
    COMMIT
  } state_t;

  state_t      state;
  logic [4:0]  idx;
  logic [4:0]  idx_next;

  logic [39:0] stg_x;
  logic [39:0] stg_y;
  logic [9:0]  stg_rot;
  logic [39:0] stg_timer;
  logic [7:0]  stg_map_x;
  logic [7:0]  stg_map_y;

  logic        rdata_unused;
  assign rdata_unused = ^rdata[15:8];

  // Actor k occupies four consecutive registers starting at its base; the map scroll sits at 6/7.
  function automatic logic [5:0] seq_addr(input logic [4:0] i);
    logic [5:0] base;
    base = 6'd0;
    if (i < 5'd20) begin
      case (i[4:2])
        3'd0:    base = 6'd0;
        3'd1:    base = 6'd8;
        3'd2:    base = 6'd14;
        3'd3:    base = 6'd20;
        default: base = 6'd26;
      endcase
      return base + {4'd0, i[1:0]};
    end else if (i == 5'd20) begin
      return 6'd6;
    end else begin
      return 6'd7;
    end
  endfunction

  assign idx_next = idx + 5'd1;

  // Write strobe follows the grant directly so the lock write completes on the granted edge.
  always_comb begin
    we = 1'b0;
    if (state == LOCK) we = bus_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      bus_req     <= 1'b0;
      reg_addr    <= '0;
      wdata       <= '0;
      busy        <= 1'b0;
      snap_valid  <= 1'b0;
      overrun     <= 1'b0;
      stg_x       <= '0;
      stg_y       <= '0;
      stg_rot     <= '0;
      stg_timer   <= '0;
      stg_map_x   <= '0;
      stg_map_y   <= '0;
      actor_x     <= '0;
      actor_y     <= '0;
      actor_rot   <= '0;
      actor_timer <= '0;
      map_x       <= '0;
      map_y       <= '0;
    end else begin
      snap_valid <= 1'b0;
      if (frame_start && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state    <= XFER;
            idx      <= '0;
            reg_addr <= seq_addr(5'd0);
            bus_req  <= 1'b1;
            busy     <= 1'b1;
          end
        end

        XFER: begin
          if (bus_gnt) begin
            if (idx < 5'd20) begin
              case (idx[1:0])
                2'd0:    stg_x[{idx[4:2], 3'b000} +: 8]     <= rdata[7:0];
                2'd1:    stg_y[{idx[4:2], 3'b000} +: 8]     <= rdata[7:0];
                2'd2:    stg_rot[{idx[4:2], 1'b0} +: 2]     <= rdata[1:0];
                default: stg_timer[{idx[4:2], 3'b000} +: 8] <= rdata[7:0];
              endcase
            end else if (idx == 5'd20) begin
              stg_map_x <= rdata[7:0];
            end else begin
              stg_map_y <= rdata[7:0];
            end

            if (idx == 5'd21) begin
              state    <= LOCK;
              reg_addr <= FRAME_LOCK_ADDR;
              wdata    <= FRAME_LOCK_VALUE;
            end else begin
              idx      <= idx_next;
              reg_addr <= seq_addr(idx_next);
            end
          end
        end

        LOCK: begin
          if (bus_gnt) begin
            state    <= COMMIT;
            reg_addr <= '0;
            wdata    <= '0;
            bus_req  <= 1'b0;
          end
        end

        COMMIT: begin
          actor_x     <= stg_x;
          actor_y     <= stg_y;
          actor_rot   <= stg_rot;
          actor_timer <= stg_timer;
          map_x       <= stg_map_x;
          map_y       <= stg_map_y;
          snap_valid  <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_snapshot_dma.sv
// Directed bench for sprite_snapshot_dma: register-file model, expected snapshots queued at
// frame start and compared when snap_valid fires.
module tb_sprite_snapshot_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        bus_gnt;
  logic        bus_req;
  logic [5:0]  reg_addr;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] rdata;
  logic [39:0] actor_x;
  logic [39:0] actor_y;
  logic [9:0]  actor_rot;
  logic [39:0] actor_timer;
  logic [7:0]  map_x;
  logic [7:0]  map_y;
  logic        snap_valid;
  logic        busy;
  logic        overrun;

  typedef struct packed {
    logic [39:0] x;
    logic [39:0] y;
    logic [9:0]  rot;
    logic [39:0] t;
    logic [7:0]  mx;
    logic [7:0]  my;
  } snap_t;

  sprite_snapshot_dma #(.FRAME_LOCK_ADDR(6'd32), .FRAME_LOCK_VALUE(16'd1)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bus_gnt(bus_gnt),
    .bus_req(bus_req), .reg_addr(reg_addr), .wdata(wdata), .we(we), .rdata(rdata),
    .actor_x(actor_x), .actor_y(actor_y), .actor_rot(actor_rot), .actor_timer(actor_timer),
    .map_x(map_x), .map_y(map_y), .snap_valid(snap_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [15:0] regs [64];
  assign rdata = regs[reg_addr];

  int          base [5] = '{0, 8, 14, 20, 26};
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          start = 0;
  int          lock_writes = 0;
  int          snap_pulses = 0;
  logic [5:0]  addr_log [$];
  logic        we_log [$];
  snap_t       exp_q [$];
  snap_t       held;
  snap_t       obs;

  assign obs = {actor_x, actor_y, actor_rot, actor_timer, map_x, map_y};

  // Register-file side: log granted accesses and apply writes half a cycle ahead of the edge.
  always @(negedge clk) begin
    if (bus_req && bus_gnt) begin
      addr_log.push_back(reg_addr);
      we_log.push_back(we);
    end
    if (we) begin
      regs[reg_addr] = wdata;
      if (reg_addr == 6'd32) lock_writes++;
    end
    if (snap_valid) snap_pulses++;
  end

  task automatic check(input string tag, input logic [191:0] o, input logic [191:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic snap_t model();
    snap_t s;
    s = '0;
    for (int k = 0; k < 5; k++) begin
      s.x[8*k +: 8]   = regs[base[k]][7:0];
      s.y[8*k +: 8]   = regs[base[k] + 1][7:0];
      s.rot[2*k +: 2] = regs[base[k] + 2][1:0];
      s.t[8*k +: 8]   = regs[base[k] + 3][7:0];
    end
    s.mx = regs[6][7:0];
    s.my = regs[7][7:0];
    return s;
  endfunction

  task automatic frame(input string tag);
    frame_start = 1'b1;
    tick();
    start = cyc;
    frame_start = 1'b0;
    check({tag, "_req_rise"}, bus_req, 1);
  endtask

  task automatic run_to_snap(input string tag, input int exp_lat);
    bit    ok;
    int    lat;
    snap_t e;
    ok = 1'b1;
    while (!snap_valid && (cyc - start) < 100) begin
      tick();
      if (!snap_valid && obs !== held) ok = 1'b0;
    end
    lat = cyc - start;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_shadow_hold"}, ok, 1);
    if (snap_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, obs, e);
      held = e;
    end else begin
      check({tag, "_scoreboard_pop"}, 0, 1);
    end
    tick();
    check({tag, "_pulse_one_cycle"}, snap_valid, 0);
    check({tag, "_busy_fall"}, {busy, bus_req}, 0);
  endtask

  task automatic randomize_regs();
    for (int a = 0; a < 64; a++) regs[a] = 16'($urandom);
    regs[32] = 16'h0;
  endtask

  initial begin
    logic [5:0] exp_addr [$];
    int         snaps0;
    int         lw0;

    randomize_regs();
    reset = 1'b1;
    frame_start = 1'b0;
    bus_gnt = 1'b1;
    held = '0;
    repeat (3) tick();
    check("reset_outputs", {obs, bus_req, reg_addr, wdata, we, snap_valid, busy, overrun}, 0);
    reset = 1'b0;
    tick();

    // Basic fetch with the documented register values
    regs[0] = 16'h0012; regs[1] = 16'h0034; regs[2] = 16'hFF03; regs[3] = 16'h0055;
    regs[8] = 16'h00A0; regs[26] = 16'h007F; regs[6] = 16'h0010; regs[7] = 16'h0020;
    addr_log.delete();
    we_log.delete();
    lw0 = lock_writes;
    snaps0 = snap_pulses;
    frame("basic");
    exp_q.push_back(model());
    run_to_snap("basic", 24);
    check("basic_x0", actor_x[7:0], 8'h12);
    check("basic_y0", actor_y[7:0], 8'h34);
    check("basic_rot0", actor_rot[1:0], 2'd3);
    check("basic_t0", actor_timer[7:0], 8'h55);
    check("basic_x1", actor_x[15:8], 8'hA0);
    check("basic_x4", actor_x[39:32], 8'h7F);
    check("basic_map", {map_x, map_y}, 16'h1020);
    check("basic_lock_once", lock_writes - lw0, 1);
    check("basic_lock_value", regs[32], 16'd1);
    check("basic_snap_pulses", snap_pulses - snaps0, 1);
    check("basic_no_overrun", overrun, 0);

    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 4; j++) exp_addr.push_back(6'(base[k] + j));
    exp_addr.push_back(6'd6);
    exp_addr.push_back(6'd7);
    exp_addr.push_back(6'd32);
    check("order_len", addr_log.size(), 23);
    for (int n = 0; n < 23 && n < addr_log.size(); n++) begin
      check($sformatf("order_addr%0d", n), addr_log[n], exp_addr[n]);
      check($sformatf("order_we%0d", n), we_log[n], (n == 22) ? 1'b1 : 1'b0);
    end

    // Grant stall at i=7 with a register update while stalled; frame 2 also tests atomicity
    randomize_regs();
    frame("stall");
    repeat (7) tick();
    check("stall_addr_before", reg_addr, 6'd11);
    bus_gnt = 1'b0;
    repeat (2) tick();
    regs[11] = 16'h00C3;
    repeat (3) tick();
    check("stall_addr_hold", {bus_req, reg_addr}, {1'b1, 6'd11});
    exp_q.push_back(model());
    bus_gnt = 1'b1;
    run_to_snap("stall", 29);
    check("stall_post_value", actor_timer[15:8], 8'hC3);

    // Overrun: second frame_start at E10 is ignored but latched
    randomize_regs();
    frame("overrun");
    exp_q.push_back(model());
    repeat (9) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_to_snap("overrun", 24);
    check("overrun_set", overrun, 1);
    snaps0 = snap_pulses;
    repeat (30) tick();
    check("overrun_no_second", {snap_pulses - snaps0, busy, bus_req}, 0);
    check("overrun_sticky", overrun, 1);

    // Reset at E12 abandons the fetch and clears everything
    randomize_regs();
    frame("rst");
    repeat (11) tick();
    lw0 = lock_writes;
    reset = 1'b1;
    tick();
    check("rst_outputs", {obs, bus_req, reg_addr, wdata, we, snap_valid, busy, overrun}, 0);
    reset = 1'b0;
    held = '0;
    repeat (3) tick();
    check("rst_no_lock", lock_writes - lw0, 0);
    check("rst_idle", {busy, bus_req, snap_valid}, 0);

    randomize_regs();
    frame("post_rst");
    exp_q.push_back(model());
    run_to_snap("post_rst", 24);
    check("post_rst_overrun", overrun, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/sprite_snapshot_dma.md
# sprite_snapshot_dma

Bus-master block sitting on the initiator side of the sprite register file port (reg_addr / in / out / we), sharing that port with the game CPU via a request/grant handshake. On each frame-start pulse it reads the motion registers of all five actors plus the world-map scroll position into a staging bank. It then writes the frame-lock register and atomically commits the staging bank to a shadow bank consumed by the video renderer. The renderer thereby sees a coherent per-frame sprite state regardless of CPU activity mid-frame.

## Interface
- FRAME_LOCK_ADDR, 6'd32: register address written at end of fetch.
- FRAME_LOCK_VALUE, 16'd1: data written to FRAME_LOCK_ADDR.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- bus_gnt  in  1  port granted to this block; may drop any cycle.
- bus_req  out  1  request for the register-file port.
- reg_addr  out  6  register address driven to the register file.
- wdata  out  16  write data to register file.
- we  out  1  write strobe.
- rdata  in  16  register file read data; combinational from reg_addr, same cycle.
- actor_x  out  40  shadow X; actor k in bits [8k+7:8k]; k=0 PacMan, 1 Blinky, 2 Pinky, 3 Inky, 4 Clyde.
- actor_y  out  40  shadow Y, same packing.
- actor_rot  out  10  shadow rotation, 2 bits per actor, rdata[1:0] of the rot register.
- actor_timer  out  40  shadow animation timer, same packing as actor_x.
- map_x, map_y  out  8 each  shadow world-map scroll.
- snap_valid  out  1  one-cycle pulse when the shadow bank updates.
- busy  out  1  fetch in progress.
- overrun  out  1  sticky; frame_start arrived while busy.

## Operation
- States:
  - IDLE: no fetch in progress.
  - XFER: reading the address sequence.
  - LOCK: writing the frame-lock register.
  - COMMIT: copying staging bank to shadow bank.
- Fetch sequence: 22 reads, index i=0..21, in address order 0,1,2,3, 8,9,10,11, 14,15,16,17, 20,21,22,23, 26,27,28,29, 6,7.
  - Each actor's group of four addresses maps to x, y, rot, timer.
  - Addresses 6 and 7 map to map_x and map_y.
- IDLE → XFER on frame_start; i cleared to 0.
- XFER:
  - reg_addr = sequence[i].
  - A read completes on an edge where bus_gnt=1. At that edge, rdata[7:0] (rdata[1:0] for rot) is captured into staging and i increments.
  - If bus_gnt=0, nothing is captured and i and reg_addr hold.
  - After the capture at i=21, go to LOCK.
- LOCK:
  - reg_addr=FRAME_LOCK_ADDR, wdata=FRAME_LOCK_VALUE, we=bus_gnt.
  - The write completes on an edge with bus_gnt=1, then go to COMMIT.
- COMMIT: copy staging to shadow in one edge, pulse snap_valid, return to IDLE.
- bus_req=1 and busy=1 in XFER and LOCK. busy also =1 in COMMIT.
- we=0 outside LOCK. reg_addr=0 and wdata=0 in IDLE and COMMIT.
- frame_start while not IDLE:
  - Ignored; the in-flight fetch continues unchanged.
  - overrun is set and stays set until reset.
- Shadow outputs change only in COMMIT, never partially.
- Reset:
  - All outputs, the shadow bank, the staging bank, i and overrun are cleared to 0; state goes to IDLE.
  - Reset mid-fetch abandons the fetch with no commit.
  - Reset has priority over frame_start in the same cycle.

## Timing
- With bus_gnt held high, counting from the edge E0 that samples frame_start=1:
  - bus_req rises after E0.
  - Reads complete at E1..E22.
  - The lock write (we=1) completes at E23.
  - Shadow updates at E24; snap_valid is high E24→E25; busy falls after E24.
- Total 24 cycles from pulse to snapshot. Each gnt-low cycle adds exactly one cycle.
- Read data is sampled at the same edge the address is presented; the register file has zero read latency.
- bus_gnt is assumed to respond combinationally or with any delay. The block makes no progress without it, and it never deasserts bus_req before the lock write completes.

## Test plan
- Basic fetch:
  - Stimulus: preload regs, e.g. reg0=0x12, reg1=0x34, reg2=0x03, reg3=0x55, reg8=0xA0, reg26=0x7F, reg6=0x10, reg7=0x20; gnt=1; pulse frame_start.
  - Response: after 24 cycles actor_x[7:0]=0x12, actor_y[7:0]=0x34, actor_rot[1:0]=3, actor_timer[7:0]=0x55, actor_x[15:8]=0xA0, actor_x[39:32]=0x7F, map_x=0x10, map_y=0x20; one snap_valid pulse; reg32 written with 1 exactly once.
- Address order:
  - Stimulus: monitor reg_addr on gnt-high edges.
  - Response: sequence 0,1,2,3,8..11,14..17,20..23,26..29,6,7,32; we=1 only on the 32 cycle.
- Grant stall:
  - Stimulus: drop bus_gnt for 5 cycles during i=7, changing reg 11 while gnt is low.
  - Response: reg_addr holds at 11; the post-stall value is captured; snapshot arrives at E29.
- Atomicity:
  - Stimulus: run frame 1, then frame 2 with changed values.
  - Response: shadow outputs keep frame 1 values until frame 2's snap_valid, then all change in the same cycle.
- Overrun:
  - Stimulus: pulse frame_start at E10 of a fetch.
  - Response: the fetch completes normally at E24; no second fetch starts; overrun=1 until reset.
- Reset mid-fetch:
  - Stimulus: assert reset at E12.
  - Response: next cycle all outputs are 0, bus_req=0, no write to reg32. A later frame_start runs a clean 24-cycle fetch.
